// File: rtl/ts_sync_monitor.sv
// MPEG transport-stream sync monitor: finds and tracks the 0x47 sync byte,
// counts sync misses and TEI flags, and flags loss of input signal.
module ts_sync_monitor #(
  parameter int unsigned PKT_LEN        = 188,
  parameter int unsigned LOCK_COUNT     = 3,
  parameter int unsigned UNLOCK_COUNT   = 3,
  parameter int unsigned SIGNAL_TIMEOUT = 1024
) (
  input  logic       wclk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] ts_data,
  input  logic       error_clr,
  output logic       valid_out,
  output logic [7:0] ts_data_out,
  output logic       pkt_start,
  output logic       sync_lock,
  output logic       signal_present,
  output logic [7:0] error_count
);

  localparam int unsigned IdxW   = $clog2(PKT_LEN);
  localparam int unsigned CntMax = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [IdxW-1:0] IdxLast  = IdxW'(PKT_LEN - 1);
  localparam logic [CntW-1:0] LockCnt  = CntW'(LOCK_COUNT);
  localparam logic [CntW-1:0] MissCnt  = CntW'(UNLOCK_COUNT);
  localparam logic [11:0]     IdleMax  = 12'(SIGNAL_TIMEOUT - 1);
  localparam logic [7:0]      SyncByte = 8'h47;

  typedef enum logic [1:0] {StHunt, StVerify, StLocked, StLoss} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d, idx_next;
  logic [CntW-1:0] good_q, good_d, miss_q, miss_d;
  logic [11:0]     idle_q, idle_d;
  logic [7:0]      err_q, err_d;
  logic            err_inc;
  logic            pst_q, pst_d;
  logic            vout_q;
  logic [7:0]      dout_q;
  logic            is_sync, at_zero;

  assign is_sync  = (ts_data == SyncByte);
  assign at_zero  = (idx_q == '0);
  assign idx_next = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;

  // Next-state for sync FSM, byte index, counters and idle timer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    good_d  = good_q;
    miss_d  = miss_q;
    err_inc = 1'b0;
    idle_d  = valid ? '0 : ((idle_q == IdleMax) ? idle_q : idle_q + 12'd1);

    if (valid) begin
      unique case (state_q)
        StHunt: begin
          if (is_sync) begin
            state_d = (LOCK_COUNT <= 1) ? StLocked : StVerify;
            idx_d   = IdxW'(1);
            good_d  = CntW'(1);
          end else begin
            idx_d = '0;
          end
        end
        StVerify: begin
          idx_d = idx_next;
          if (at_zero) begin
            if (is_sync) begin
              good_d = good_q + 1'b1;
              if (good_q + 1'b1 == LockCnt) state_d = StLocked;
            end else begin
              state_d = StHunt;
              idx_d   = '0;
              good_d  = '0;
            end
          end
        end
        StLocked: begin
          idx_d = idx_next;
          if (at_zero && !is_sync) begin
            state_d = StLoss;
            miss_d  = CntW'(1);
            err_inc = 1'b1;
          end
          // Transport error indicator is bit 7 of the byte after sync.
          if (idx_q == IdxW'(1) && ts_data[7]) err_inc = 1'b1;
        end
        StLoss: begin
          idx_d = idx_next;
          if (at_zero) begin
            if (is_sync) begin
              state_d = StLocked;
              miss_d  = '0;
            end else begin
              miss_d  = miss_q + 1'b1;
              err_inc = 1'b1;
              if (miss_q + 1'b1 == MissCnt) begin
                state_d = StHunt;
                idx_d   = '0;
                miss_d  = '0;
              end
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    // Signal timeout overrides whatever the FSM decided.
    if (idle_d == IdleMax) begin
      state_d = StHunt;
      idx_d   = '0;
      good_d  = '0;
      miss_d  = '0;
    end

    pst_d = valid && at_zero && is_sync && (state_d == StLocked || state_d == StLoss);

    if (error_clr)                     err_d = '0;
    else if (err_inc && err_q != '1)   err_d = err_q + 8'd1;
    else                               err_d = err_q;
  end

  // State and output registers.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHunt;
      idx_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      idle_q  <= '0;
      err_q   <= '0;
      pst_q   <= 1'b0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      pst_q   <= pst_d;
      vout_q  <= valid;
      dout_q  <= ts_data;
    end
  end

  assign valid_out      = vout_q;
  assign ts_data_out    = dout_q;
  assign pkt_start      = pst_q;
  assign sync_lock      = (state_q == StLocked) || (state_q == StLoss);
  assign signal_present = (idle_q < IdleMax);
  assign error_count    = err_q;

endmodule

// File: tb/tb_ts_sync_monitor.sv
// Randomized bench for ts_sync_monitor against a behavioural sync model.
module tb_ts_sync_monitor;

  localparam int PktLen    = 188;
  localparam int LockCnt   = 3;
  localparam int UnlockCnt = 3;
  localparam int Timeout   = 1024;

  localparam int MHunt   = 0;
  localparam int MVerify = 1;
  localparam int MLocked = 2;
  localparam int MLoss   = 3;

  logic       wclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] ts_data = '0;
  logic       error_clr = 1'b0;
  logic       valid_out;
  logic [7:0] ts_data_out;
  logic       pkt_start;
  logic       sync_lock;
  logic       signal_present;
  logic [7:0] error_count;

  ts_sync_monitor #(
    .PKT_LEN       (PktLen),
    .LOCK_COUNT    (LockCnt),
    .UNLOCK_COUNT  (UnlockCnt),
    .SIGNAL_TIMEOUT(Timeout)
  ) dut (
    .wclk          (wclk),
    .rst_n         (rst_n),
    .valid         (valid),
    .ts_data       (ts_data),
    .error_clr     (error_clr),
    .valid_out     (valid_out),
    .ts_data_out   (ts_data_out),
    .pkt_start     (pkt_start),
    .sync_lock     (sync_lock),
    .signal_present(signal_present),
    .error_count   (error_count)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;
  int n_pst    = 0;

  // Reference model state.
  int m_mode, m_pos, m_good, m_miss, m_idle, m_err;
  int e_vout, e_dout, e_pst;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MHunt; m_pos = 0; m_good = 0; m_miss = 0; m_idle = 0; m_err = 0;
    e_vout = 0; e_dout = 0; e_pst = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit clr);
    bit at0, s, inc;
    inc = 0;
    e_vout = v;
    e_dout = d;
    e_pst  = 0;
    if (v) m_idle = 0;
    else if (m_idle < Timeout - 1) m_idle++;
    if (v) begin
      at0 = (m_pos == 0);
      s   = (d == 8'h47);
      case (m_mode)
        MHunt: begin
          if (s) begin m_mode = MVerify; m_good = 1; end
        end
        MVerify: begin
          if (at0) begin
            if (s) begin
              m_good++;
              if (m_good == LockCnt) m_mode = MLocked;
            end else begin
              m_mode = MHunt; m_good = 0;
            end
          end
        end
        MLocked: begin
          if (at0 && !s) begin m_mode = MLoss; m_miss = 1; inc = 1; end
          if (m_pos == 1 && d[7]) inc = 1;
        end
        default: begin
          if (at0) begin
            if (s) begin
              m_mode = MLocked; m_miss = 0;
            end else begin
              m_miss++; inc = 1;
              if (m_miss == UnlockCnt) begin m_mode = MHunt; m_miss = 0; end
            end
          end
        end
      endcase
      m_pos = (m_mode == MHunt) ? 0 : (m_pos + 1) % PktLen;
      e_pst = (at0 && s && m_mode >= MLocked) ? 1 : 0;
    end else if (m_idle == Timeout - 1) begin
      m_mode = MHunt; m_pos = 0; m_good = 0; m_miss = 0;
    end
    if (clr) m_err = 0;
    else if (inc && m_err < 255) m_err++;
  endtask

  task automatic compare_all();
    check("valid_out", 32'(valid_out), 32'(e_vout));
    check("ts_data_out", 32'(ts_data_out), 32'(e_dout));
    check("pkt_start", 32'(pkt_start), 32'(e_pst));
    check("sync_lock", 32'(sync_lock), (m_mode >= MLocked) ? 32'd1 : 32'd0);
    check("signal_present", 32'(signal_present), (m_idle < Timeout - 1) ? 32'd1 : 32'd0);
    check("error_count", 32'(error_count), 32'(m_err));
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit clr);
    @(negedge wclk);
    valid = v;
    ts_data = d;
    error_clr = clr;
    model_step(v, d, clr);
    @(posedge wclk);
    #1;
    compare_all();
    if (pkt_start) n_pst++;
  endtask

  // tei: 0 clears bit 7 of byte 1, 1 sets it, 2 leaves it random.
  task automatic send_pkt(input logic [7:0] sync, input int tei, input int gap_pct,
                          input bit allow47, input bit clr_at1, input int n_bytes);
    logic [7:0] b;
    for (int i = 0; i < n_bytes; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) cycle(1'b0, 8'($urandom), 1'b0);
      b = (i == 0) ? sync : 8'($urandom);
      if (i == 1 && tei == 0) b[7] = 1'b0;
      if (i == 1 && tei == 1) b[7] = 1'b1;
      if (i != 0 && !allow47 && b == 8'h47) b = 8'h46;
      cycle(1'b1, b, (i == 1) ? clr_at1 : 1'b0);
    end
  endtask

  task automatic clean_pkts(input int n);
    for (int p = 0; p < n; p++) send_pkt(8'h47, 0, 6, 1'b0, 1'b0, PktLen);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    check({tag, "_ts_data_out"}, 32'(ts_data_out), 32'd0);
    check({tag, "_pkt_start"}, 32'(pkt_start), 32'd0);
    check({tag, "_sync_lock"}, 32'(sync_lock), 32'd0);
    check({tag, "_signal_present"}, 32'(signal_present), 32'd1);
    check({tag, "_error_count"}, 32'(error_count), 32'd0);
    valid = 1'b0;
    error_clr = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset("rst0");

    // Clean lock: one pkt_start pulse, on the third sync.
    clean_pkts(2);
    check("lock_after_2", 32'(sync_lock), 32'd0);
    clean_pkts(1);
    check("lock_after_3", 32'(sync_lock), 32'd1);
    check("pst_count_3", 32'(n_pst), 32'd1);
    check("err_clean", 32'(error_count), 32'd0);

    // Single corrupted sync.
    send_pkt(8'h00, 0, 6, 1'b0, 1'b0, PktLen);
    check("single_miss_lock", 32'(sync_lock), 32'd1);
    check("single_miss_err", 32'(error_count), 32'd1);
    clean_pkts(1);
    check("single_miss_relock", 32'(sync_lock), 32'd1);

    // Three consecutive misses drop lock; three good syncs relock.
    cycle(1'b0, 8'h00, 1'b1);
    for (int p = 0; p < 3; p++) send_pkt(8'h00, 0, 6, 1'b0, 1'b0, PktLen);
    check("triple_miss_lock", 32'(sync_lock), 32'd0);
    check("triple_miss_err", 32'(error_count), 32'd3);
    clean_pkts(2);
    check("relock_2", 32'(sync_lock), 32'd0);
    clean_pkts(1);
    check("relock_3", 32'(sync_lock), 32'd1);

    // Signal loss while locked.
    repeat (Timeout) cycle(1'b0, 8'($urandom), 1'b0);
    check("timeout_present", 32'(signal_present), 32'd0);
    check("timeout_lock", 32'(sync_lock), 32'd0);
    cycle(1'b1, 8'h00, 1'b0);
    check("timeout_restore", 32'(signal_present), 32'd1);

    // TEI saturation, then clear colliding with an increment.
    clean_pkts(3);
    for (int p = 0; p < 300; p++) send_pkt(8'h47, 1, 0, 1'b0, 1'b0, PktLen);
    check("tei_saturate", 32'(error_count), 32'd255);
    send_pkt(8'h47, 1, 0, 1'b0, 1'b1, PktLen);
    check("clr_wins", 32'(error_count), 32'd0);

    // Asynchronous reset at byte 90 of a locked packet.
    send_pkt(8'h47, 1, 0, 1'b0, 1'b0, 90);
    check("pre_reset_lock", 32'(sync_lock), 32'd1);
    do_reset("rst_mid");
    clean_pkts(2);
    check("post_reset_relock_2", 32'(sync_lock), 32'd0);
    clean_pkts(1);
    check("post_reset_relock_3", 32'(sync_lock), 32'd1);

    // Random stream: corrupt syncs, random TEI, stray 0x47, gaps, clears.
    for (int p = 0; p < 20; p++) begin
      logic [7:0] s;
      s = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h47;
      send_pkt(s, 2, 10, 1'b1, ($urandom_range(7) == 0), PktLen);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ts_sync_monitor.md
TS_SYNC_MONITOR -- requirements
Module: ts_sync_monitor

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- PKT_LEN, 188, bytes per TS packet.
- LOCK_COUNT, 3, consecutive good sync bytes needed to lock.
- UNLOCK_COUNT, 3, consecutive missed sync bytes needed to drop lock.
- SIGNAL_TIMEOUT, 1024, cycles without valid before signal is declared absent.
REQ-002 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- wclk, in, 1, byte clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- valid, in, 1, ts_data carries a byte this cycle.
- ts_data, in, 8, TS byte stream.
- error_clr, in, 1, synchronous clear of error_count.
- valid_out, out, 1, valid delayed by 1 cycle.
- ts_data_out, out, 8, ts_data delayed by 1 cycle.
- pkt_start, out, 1, marks the sync byte on the output stream while locked.
- sync_lock, out, 1, state is LOCKED or LOSS.
- signal_present, out, 1, valid seen within SIGNAL_TIMEOUT cycles.
- error_count, out, 8, saturating error counter.

Function
REQ-004 The state machine SHALL have the states HUNT, VERIFY, LOCKED and LOSS; it SHALL advance only on cycles with valid=1.
REQ-005 The byte index SHALL be 0..PKT_LEN-1, wrap from PKT_LEN-1 to 0, and be checked against 0x47 at index 0.
REQ-006 In HUNT, a byte equal to 0x47 SHALL move the FSM to VERIFY with index=1 and good=1; any other byte SHALL keep the FSM in HUNT.
REQ-007 In VERIFY, a byte at index 0 equal to 0x47 SHALL increment good; when good reaches LOCK_COUNT, the FSM SHALL move to LOCKED. A non-0x47 byte at index 0 SHALL move the FSM to HUNT.
REQ-008 In LOCKED, a missed sync at index 0 SHALL move the FSM to LOSS with miss=1 and increment error_count.
REQ-009 In LOSS, a good sync SHALL move the FSM to LOCKED with miss=0. A missed sync SHALL increment miss and error_count; when miss reaches UNLOCK_COUNT, the FSM SHALL move to HUNT.
REQ-010 In LOCKED, a byte at index 1 with bit 7 set (TEI) SHALL increment error_count.
REQ-011 Output latency SHALL be 1 cycle: valid_out, ts_data_out and pkt_start SHALL be registered together.
REQ-012 pkt_start SHALL be 1 only when valid=1, the byte is at index 0, the byte equals 0x47, and the FSM is in LOCKED or LOSS.
REQ-013 error_count SHALL saturate at 255.
REQ-014 error_clr SHALL set error_count to 0 on the next edge and SHALL win over a same-cycle increment.
REQ-015 A 12-bit idle counter SHALL clear on valid=1 and otherwise count up to SIGNAL_TIMEOUT-1 and hold there.
REQ-016 signal_present SHALL be 1 while the idle counter is below SIGNAL_TIMEOUT-1.
REQ-017 When the idle counter reaches SIGNAL_TIMEOUT-1, the FSM SHALL be forced to HUNT, and this force SHALL override any transition in the same cycle.
REQ-018 A gap in valid (valid=0) SHALL freeze the byte index and FSM; it SHALL not count as a miss.

Reset
REQ-019 Asserting rst_n=0 at any time, including mid-packet, SHALL immediately set the FSM to HUNT, the index, good and miss to 0, the idle counter to 0, and error_count to 0.
REQ-020 During reset, all outputs SHALL be 0 except signal_present, which SHALL be 1.
REQ-021 After rst_n deasserts, the first valid byte SHALL be processed in HUNT.

Verification
REQ-022 Clean stream of 3 packets, sync 0x47 every 188 bytes -> sync_lock rises 1 cycle after the 3rd sync byte; pkt_start pulses with the 3rd sync on valid_out; error_count=0.
REQ-023 While locked, corrupt the sync of 1 packet to 0x00 -> sync_lock stays 1; error_count=1; next good sync returns the FSM to LOCKED.
REQ-024 While locked, corrupt 3 consecutive syncs -> sync_lock falls after the 3rd miss; error_count=3; relock requires 3 good syncs.
REQ-025 Hold valid=0 for 1024 cycles while locked -> signal_present=0 and sync_lock=0; the first valid byte afterwards restores signal_present=1.
REQ-026 Force 300 TEI packets and pulse error_clr in the same cycle as an increment -> error_count saturates at 255, then reads 0 after the clear.
REQ-027 Assert rst_n=0 at byte 90 of a locked packet -> all outputs reset asynchronously; relock takes 3 packets after release.
